// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour replay sequencer and the
// tour solver's offset functions.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } tour_state_e;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [4:0] LAST_MOVE_IDX = 5'd23;

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command/response bundle between the UART wrapper, the tour sequencer and the
// motion controller.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  // master: the sequencer; slave: the UART wrapper and motion controller side
  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_move_decode.sv
// One-hot knight move to signed (dx, dy) offsets; +x east, +y north.
// Anything that is not exactly one-hot decodes to (0, 0).
module tour_move_decode (
  input  logic [7:0]        move,
  output logic signed [2:0] dx,
  output logic signed [2:0] dy
);

  always_comb begin
    dx = '0;
    dy = '0;
    case (move)
      8'h01: begin dx = -3'sd1; dy =  3'sd2; end
      8'h02: begin dx =  3'sd1; dy =  3'sd2; end
      8'h04: begin dx = -3'sd2; dy =  3'sd1; end
      8'h08: begin dx = -3'sd2; dy = -3'sd1; end
      8'h10: begin dx = -3'sd1; dy = -3'sd2; end
      8'h20: begin dx =  3'sd1; dy = -3'sd2; end
      8'h40: begin dx =  3'sd2; dy = -3'sd1; end
      8'h80: begin dx =  3'sd2; dy =  3'sd1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as vertical-then-horizontal motion commands,
// passing UART commands through when idle. Macro TOUR_FANFARE_EN selects the
// fanfare opcode for the horizontal leg.
module tour_cmd_seq
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic        tour_busy,
  tour_cmd_seq_if.master bus
);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] H_OP = OP_FANFARE;
`else
  localparam logic [3:0] H_OP = OP_MOVE;
`endif

  tour_state_e       state, state_nxt;
  logic [4:0]        indx_nxt;
  logic signed [2:0] dx, dy;
  logic [2:0]        dx_mag, dy_mag;
  logic [15:0]       vleg, hleg;

  tour_move_decode u_decode (
    .move (move),
    .dx   (dx),
    .dy   (dy)
  );

  // Zero offsets take the south/west heading; the 0-square count makes it a no-op.
  assign dx_mag = dx[2] ? 3'(-dx) : 3'(dx);
  assign dy_mag = dy[2] ? 3'(-dy) : 3'(dy);
  assign vleg   = {OP_MOVE, (!dy[2] && dy != '0) ? HDG_N : HDG_S, {1'b0, dy_mag}};
  assign hleg   = {H_OP,    (!dx[2] && dx != '0) ? HDG_E : HDG_W, {1'b0, dx_mag}};

  assign tour_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= state_nxt;
      mv_indx <= indx_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    indx_nxt             = mv_indx;
    bus.cmd              = vleg;
    bus.cmd_rdy          = 1'b0;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = 8'hA5;
    case (state)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = 8'h5A;
        if (start_tour) begin
          state_nxt = VERT;
          indx_nxt  = '0;
        end
      end
      VERT: begin
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_nxt = HOLD_V;
      end
      HOLD_V: begin
        if (bus.send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        bus.cmd     = hleg;
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        bus.cmd = hleg;
        if (bus.send_resp) begin
          if (mv_indx == LAST_MOVE_IDX) begin
            bus.resp  = 8'h5A;
            state_nxt = IDLE;
            indx_nxt  = '0;
          end else begin
            state_nxt = VERT;
            indx_nxt  = mv_indx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequencer that replays a solved 5x5 knight's tour into the motion command stream. After the tour solver reports completion, it walks move indices 0..23, reads each one-hot move, and splits it into two legs: vertical, then horizontal. It issues each leg as a 16-bit motion command using the same ready/clear handshake the UART command path uses. When no tour is running, it passes UART commands through unchanged.

## Interface
- No parameters.
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- start_tour  in  1  one-cycle pulse; tour solution complete, begin replay
- move  in  8  one-hot move at index mv_indx; combinationally valid the same cycle mv_indx changes
- mv_indx  out  5  index of move being replayed, 0..23
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid (level)
- clr_cmd_rdy_UART  out  1  consume UART command
- cmd  out  16  command to motion controller
- cmd_rdy  out  1  cmd valid (level)
- clr_cmd_rdy  in  1  motion controller consumed cmd
- send_resp  in  1  one-cycle pulse; motion controller finished the command
- resp  out  8  response byte to UART: 8'hA5 = intermediate, 8'h5A = final/idle
- tour_busy  out  1  high in every state except IDLE

## Operation
- Move decode, as (dx, dy) with +x = east and +y = north:
  - bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Command format: cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] squares.
  - Opcode: MOVE = 4'h2, MOVE_FANFARE = 4'h3.
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Vertical leg: {4'h2, north if dy>0 else south, |dy|}.
- Horizontal leg: {H_OP, east if dx>0 else west, |dx|}. H_OP is set in Configuration.
- States:
  - IDLE: passthrough. cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
    - start_tour -> mv_indx<=0, go to VERT.
  - VERT: cmd=vertical leg, cmd_rdy=1.
    - clr_cmd_rdy -> HOLD_V.
  - HOLD_V: cmd_rdy=0.
    - send_resp -> HORZ.
  - HORZ: cmd=horizontal leg, cmd_rdy=1.
    - clr_cmd_rdy -> HOLD_H.
  - HOLD_H: cmd_rdy=0.
    - send_resp with mv_indx==23 -> IDLE, mv_indx<=0.
    - send_resp with mv_indx<23 -> mv_indx<=mv_indx+1, VERT.
- UART path outside IDLE: cmd_rdy_UART is masked, clr_cmd_rdy_UART=0. A pending UART command stays pending and is forwarded after return to IDLE.
- resp: 8'h5A in IDLE and on the final send_resp (HOLD_H, mv_indx==23). 8'hA5 otherwise.
- Non-one-hot move: decodes to dx=dy=0, producing 0-square commands. Behaviour is defined; the data is the solver's responsibility.

## Timing
- Reset values: state IDLE, mv_indx 0, tour_busy 0, cmd_rdy = cmd_rdy_UART (passthrough), clr_cmd_rdy_UART = clr_cmd_rdy, resp 8'h5A.
- State and mv_indx are the only registers. All outputs are combinational from state, mv_indx, move and the passthrough inputs.
- start_tour sampled at edge N -> cmd_rdy=1 with first vertical leg from N+1.
- clr_cmd_rdy sampled at edge M -> cmd_rdy=0 from M+1.
- send_resp sampled in HOLD_x at edge K -> next leg's cmd_rdy high from K+1.
- start_tour outside IDLE is ignored.
- start_tour and cmd_rdy_UART in the same IDLE cycle: the tour wins, and clr_cmd_rdy_UART follows clr_cmd_rdy only during that cycle.
- send_resp in VERT/HORZ or clr_cmd_rdy in HOLD_x: ignored.
- rst_n low mid-tour: immediate return to IDLE, mv_indx=0; no resume.
- Total tour = 48 command handshakes.

## Configuration
- TOUR_FANFARE_EN defined: H_OP = 4'h3, so the horizontal leg (end of each knight move) plays fanfare.
- Not defined: H_OP = 4'h2, and all 48 commands are plain moves.

## Structure
- Package tour_pkg:
  - state enum (IDLE, VERT, HOLD_V, HORZ, HOLD_H)
  - opcode constants OP_MOVE and OP_FANFARE
  - heading constants HDG_N, HDG_W, HDG_S, HDG_E
  - constant LAST_MOVE_IDX = 23
- Sub-module tour_move_decode: combinational, move[7:0] -> signed 3-bit dx, dy. The same package is shared with the solver's offset functions.

## Test plan
- Reset, then cmd_UART=16'h2003 with cmd_rdy_UART=1 in IDLE -> cmd=16'h2003, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1 the same cycle.
- start_tour with move=8'h01 -> cmd=16'h2002; after clr_cmd_rdy and send_resp -> cmd=16'h33F1 (16'h23F1 without TOUR_FANFARE_EN); resp=8'hA5.
- move=8'h80 -> 16'h2001 then 16'h3BF2. move=8'h10 -> 16'h27F2 then 16'h33F1.
- Full 24-move replay with a model responder -> mv_indx 0..23 in order, 48 commands, resp=8'h5A on the final send_resp, tour_busy falls the next cycle.
- cmd_rdy_UART=1 during a tour -> cmd_rdy reflects only tour legs and clr_cmd_rdy_UART stays 0; the UART command is forwarded after IDLE.
- rst_n asserted in HOLD_H at mv_indx=7 -> IDLE, mv_indx=0, tour_busy=0 immediately; a second start_tour while busy is ignored (mv_indx is not reset).
